// File: rtl/pool2_exec_pkg.sv
// Shared definitions for the S4 (pool2) stage.
// Holds the map geometry, derived widths and a channel-slice helper used by the
// top level when wiring the per-channel max units.
package pool2_exec_pkg;

  localparam int unsigned DW       = 16;  // per-channel width, signed fixed point
  localparam int unsigned CH       = 16;  // channels per beat
  localparam int unsigned MAP_W    = 8;   // input map width (even)
  localparam int unsigned MAP_H    = 8;   // input map height (even)
  localparam int unsigned S4_WORDS = (MAP_W / 2) * (MAP_H / 2);

  localparam int unsigned WORD_W = CH * DW;
  localparam int unsigned COL_W  = $clog2(MAP_W);
  localparam int unsigned ROW_W  = $clog2(MAP_H);
  localparam int unsigned LB_N   = MAP_W / 2;
  localparam int unsigned LB_W   = $clog2(LB_N);
  localparam int unsigned ADDR_W = $clog2(S4_WORDS);

  // Channel k of a packed word (k = 0 at the LSB end).
  function automatic logic [DW-1:0] ch_slice(input logic [WORD_W-1:0] word,
                                             input int unsigned k);
    return word[k*DW +: DW];
  endfunction

endpackage

// File: rtl/pool_max2.sv
// Combinational signed 2-input max for one channel.
// Ports:
//   a, b : DW-bit signed operands
//   y    : the larger of a and b (a on a tie; both are equal then)
module pool_max2
  import pool2_exec_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y
);

  assign y = ($signed(a) >= $signed(b)) ? a : b;

endmodule

// File: rtl/pool2_exec.sv
// S4 streaming 2x2 / stride-2 max pooling over the 16-channel conv2 map.
// Pixels arrive in raster order, one 16-channel word per in_valid beat. Even
// columns park in a hold register; odd columns of even rows store the horizontal
// max into a small line buffer; odd columns of odd rows combine with the line
// buffer and emit one pooled word with its window address.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   clear              : synchronous frame restart (wins over in_valid)
//   in_valid, in_data  : input pixel beat
//   out_valid          : 1-cycle pulse per completed window
//   out_data, out_addr : pooled word and window index prow*(MAP_W/2)+pcol
//   frame_done         : pulses with the last window of the frame
module pool2_exec
  import pool2_exec_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              frame_done
);

  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic [WORD_W-1:0] hold_q;
  logic [WORD_W-1:0] lbuf_q [LB_N];

  logic [WORD_W-1:0] hmax;
  logic [WORD_W-1:0] vmax;
  logic [WORD_W-1:0] lbuf_rd;
  logic [LB_W-1:0]   pcol;
  logic [ROW_W-2:0]  prow;
  logic              col_last;
  logic              row_last;
  logic [ADDR_W-1:0] win_addr;

  assign pcol     = col_q[COL_W-1:1];
  assign prow     = row_q[ROW_W-1:1];
  assign col_last = (col_q == COL_W'(MAP_W - 1));
  assign row_last = (row_q == ROW_W'(MAP_H - 1));
  assign lbuf_rd  = lbuf_q[pcol];
  assign win_addr = ADDR_W'(int'(prow) * int'(LB_N) + int'(pcol));

  // Horizontal stage pairs the held even pixel with the current odd pixel;
  // vertical stage folds in the row above from the line buffer.
  for (genvar k = 0; k < CH; k++) begin : g_ch
    pool_max2 u_hmax (
      .a (ch_slice(hold_q, k)),
      .b (ch_slice(in_data, k)),
      .y (hmax[k*DW +: DW])
    );
    pool_max2 u_vmax (
      .a (hmax[k*DW +: DW]),
      .b (ch_slice(lbuf_rd, k)),
      .y (vmax[k*DW +: DW])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      row_q      <= '0;
      hold_q     <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_addr   <= '0;
      frame_done <= 1'b0;
      for (int i = 0; i < int'(LB_N); i++) begin
        lbuf_q[i] <= '0;
      end
    end else if (clear) begin
      // Hold register and line buffer are always rewritten before use.
      col_q      <= '0;
      row_q      <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (in_valid) begin
        if (col_last) begin
          col_q <= '0;
          row_q <= row_last ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end

        if (!col_q[0]) begin
          hold_q <= in_data;
        end else if (!row_q[0]) begin
          lbuf_q[pcol] <= hmax;
        end else begin
          out_data   <= vmax;
          out_addr   <= win_addr;
          out_valid  <= 1'b1;
          frame_done <= col_last && row_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_pool2_exec.sv
// Self-checking bench for pool2_exec: a pixel-array reference model pushes the
// expected pooled word for every window as its 4th pixel is driven; a monitor
// pops and compares on every out_valid.
module tb_pool2_exec;

  localparam int W  = 256;
  localparam int MW = 8;
  localparam int MH = 8;

  logic         clk;
  logic         rst_n;
  logic         clear;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [3:0]   out_addr;
  logic         frame_done;

  pool2_exec dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] data;
    logic [3:0]   addr;
    logic         done;
  } exp_t;

  exp_t         sb [$];
  logic [W-1:0] pix [MH][MW];
  logic [W-1:0] last_out [16];
  int           pr;
  int           pc;
  int           n_tests;
  int           n_fail;
  int           n_out;
  logic         prev_v;

  task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rep(input logic [15:0] v);
    return {16{v}};
  endfunction

  // kind 0: ramp, 1: signed corner cases, 2: per-channel p^k, 3: ramp+100
  function automatic logic [W-1:0] pixel_val(input int kind, input int r, input int c);
    logic [W-1:0] w;
    logic [15:0]  tbl [8];
    int           p;
    p = r * MW + c;
    tbl = '{16'hFFFB, 16'hFFFE, 16'h8000, 16'h7FFF, 16'hFFF9, 16'hFFFD, 16'h0000, 16'h0001};
    w = rep(16'(p));
    case (kind)
      1: begin
        w = rep(16'(-p));
        if (r < 2 && c < 4) w = rep(tbl[r*4+c]);
      end
      2: for (int k = 0; k < 16; k++) w[k*16 +: 16] = 16'(p ^ k);
      3: w = rep(16'(p + 100));
      default: ;
    endcase
    return w;
  endfunction

  // Record the accepted pixel; on a window's 4th pixel push the 4-way max.
  task automatic model_accept(input logic [W-1:0] d);
    exp_t e;
    logic signed [15:0] m;
    logic signed [15:0] v;
    pix[pr][pc] = d;
    if ((pr % 2 == 1) && (pc % 2 == 1)) begin
      for (int k = 0; k < 16; k++) begin
        m = pix[pr-1][pc-1][k*16 +: 16];
        v = pix[pr-1][pc][k*16 +: 16];   if (v > m) m = v;
        v = pix[pr][pc-1][k*16 +: 16];   if (v > m) m = v;
        v = pix[pr][pc][k*16 +: 16];     if (v > m) m = v;
        e.data[k*16 +: 16] = m;
      end
      e.addr = 4'((pr / 2) * (MW / 2) + pc / 2);
      e.done = (pr == MH - 1) && (pc == MW - 1);
      sb.push_back(e);
    end
    if (pc == MW - 1) begin
      pc = 0;
      pr = (pr == MH - 1) ? 0 : pr + 1;
    end else begin
      pc++;
    end
  endtask

  task automatic beat(input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    model_accept(d);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int kind, input int gap_pct, input int n_beats);
    for (int b = 0; b < n_beats; b++) begin
      if (gap_pct > 0) begin
        while ($urandom_range(99) < gap_pct) idle(1);
      end
      beat(pixel_val(kind, b / MW, b % MW));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_valid"}, out_valid, 0);
    check_val({tag, "_data"}, out_data, 0);
    check_val({tag, "_addr"}, out_addr, 0);
    check_val({tag, "_done"}, frame_done, 0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v <= 1'b0;
    end else begin
      if (out_valid) begin
        exp_t e;
        check_val("valid_gap", prev_v, 0);
        check_val("out_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check_val("out_data", out_data, e.data);
          check_val("out_addr", out_addr, e.addr);
          check_val("frame_done", frame_done, e.done);
        end
        last_out[out_addr] <= out_data;
        n_out <= n_out + 1;
      end else if (frame_done) begin
        check_val("done_wo_valid", frame_done, 0);
      end
      prev_v <= out_valid;
    end
  end

  initial begin
    int start;
    n_tests  = 0;
    n_fail   = 0;
    n_out    = 0;
    pr       = 0;
    pc       = 0;
    rst_n    = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    idle(3);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    idle(2);

    // Gap-free ramp
    start = n_out;
    send_frame(0, 0, MW * MH);
    idle(3);
    check_val("ramp_count", 32'(n_out - start), 16);
    check_val("ramp_w0", last_out[0], rep(16'd9));
    check_val("ramp_w5", last_out[5], rep(16'd27));
    check_val("ramp_w15", last_out[15], rep(16'd63));

    // Signed corner cases
    send_frame(1, 0, MW * MH);
    idle(3);
    check_val("signed_w0", last_out[0], rep(16'hFFFE));
    check_val("signed_w1", last_out[1], rep(16'h7FFF));

    // Per-channel independence
    send_frame(2, 0, MW * MH);
    idle(3);

    // Random ~40% idle gaps on the ramp
    start = n_out;
    send_frame(0, 40, MW * MH);
    idle(3);
    check_val("gap_count", 32'(n_out - start), 16);
    check_val("gap_w5", last_out[5], rep(16'd27));

    // Back-to-back frames, then a partial frame cut by clear
    start = n_out;
    send_frame(0, 0, MW * MH);
    send_frame(3, 0, MW * MH);
    idle(3);
    check_val("b2b_count", 32'(n_out - start), 32);
    send_frame(2, 0, 37);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = rep(16'h7FFF);
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    pr = 0;
    pc = 0;
    check_val("clear_valid", out_valid, 0);
    check_val("clear_done", frame_done, 0);
    start = n_out;
    send_frame(3, 0, MW * MH);
    idle(3);
    check_val("post_clear_count", 32'(n_out - start), 16);
    check_val("post_clear_w0", last_out[0], rep(16'd109));

    // Reset asserted during beat 20
    send_frame(0, 0, 20);
    in_valid = 1'b1;
    in_data  = pixel_val(0, 2, 4);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    sb.delete();
    pr = 0;
    pc = 0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    start = n_out;
    send_frame(0, 0, MW * MH);
    idle(3);
    check_val("post_reset_count", 32'(n_out - start), 16);
    check_val("post_reset_w15", last_out[15], rep(16'd63));

    check_val("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
